// File: rtl/tick_period_meter_if.sv
// Tick measurement bus: tick input and timeout limit in, measurement results out.
interface tick_period_meter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             tick_in;
  logic [WIDTH-1:0] max_period;
  logic [WIDTH-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  modport master (
    output tick_in, max_period,
    input  period_out, period_valid, locked, timeout
  );

  modport slave (
    input  tick_in, max_period,
    output period_out, period_valid, locked, timeout
  );
endinterface

// File: rtl/tick_period_meter.sv
// Measures tick spacing as a divider value (N for ticks every N+1 cycles),
// declares lock after LOCK_COUNT equal measurements and flags missing ticks.
module tick_period_meter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic               clk_in,
  input  logic               RST,
  tick_period_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t           state, state_nx;
  logic [WIDTH-1:0] counter, counter_nx;
  logic [WIDTH-1:0] period_nx;
  logic [3:0]       match_cnt, match_nx;
  logic             valid_nx, locked_nx, timeout_nx;

  always_ff @(posedge clk_in) begin
    if (!RST) begin
      state            <= IDLE;
      counter          <= '0;
      match_cnt        <= '0;
      bus.period_out   <= '0;
      bus.period_valid <= 1'b0;
      bus.locked       <= 1'b0;
      bus.timeout      <= 1'b0;
    end else begin
      state            <= state_nx;
      counter          <= counter_nx;
      match_cnt        <= match_nx;
      bus.period_out   <= period_nx;
      bus.period_valid <= valid_nx;
      bus.locked       <= locked_nx;
      bus.timeout      <= timeout_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    counter_nx = counter;
    match_nx   = match_cnt;
    period_nx  = bus.period_out;
    valid_nx   = 1'b0;
    locked_nx  = bus.locked;
    timeout_nx = 1'b0;
    unique case (state)
      IDLE: begin
        counter_nx = '0;
        if (bus.tick_in) state_nx = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (bus.tick_in) begin
          counter_nx = '0;
          period_nx  = counter;
          valid_nx   = 1'b1;
          if (counter == bus.period_out && match_cnt != '0)
            match_nx = (match_cnt >= LOCK_N) ? LOCK_N : match_cnt + 4'd1;
          else
            match_nx = 4'd1;
          if (match_nx == LOCK_N) begin
            locked_nx = 1'b1;
            state_nx  = LOCKED;
          end else begin
            locked_nx = 1'b0;
            state_nx  = MEASURE;
          end
        // >= rather than == so a limit lowered mid-measurement still stops the counter
        end else if (counter >= bus.max_period) begin
          timeout_nx = 1'b1;
          locked_nx  = 1'b0;
          match_nx   = '0;
          counter_nx = '0;
          state_nx   = IDLE;
        end else begin
          counter_nx = counter + WIDTH'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tick_period_meter.sv
// Scoreboard bench for tick_period_meter: a timestamp-based reference model
// queues the expected outputs per cycle and a negedge monitor compares them.
module tb_tick_period_meter;
  localparam int unsigned W = 32;
  localparam int unsigned L = 4;

  logic clk_in = 1'b0;
  logic RST    = 1'b0;
  always #5 clk_in = ~clk_in;

  tick_period_meter_if #(.WIDTH(W)) bus ();

  tick_period_meter #(.WIDTH(W), .LOCK_COUNT(L)) dut (
    .clk_in (clk_in),
    .RST    (RST),
    .bus    (bus)
  );

  typedef struct {
    logic         pv;
    logic         to;
    logic         lk;
    logic [W-1:0] per;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: ticks remembered by cycle timestamp, no counter register.
  longint cyc       = 0;
  longint last_tick = 0;
  bit     have_ref  = 0;
  int     run       = 0;
  bit     mlock     = 0;
  longint mper      = 0;

  task automatic model_step(input logic t, input logic r, input logic [W-1:0] maxp);
    exp_t   e;
    longint elapsed;
    e.pv = 1'b0; e.to = 1'b0;
    if (!r) begin
      have_ref = 0; run = 0; mlock = 0; mper = 0;
    end else if (!have_ref) begin
      if (t) begin
        have_ref  = 1;
        last_tick = cyc;
      end
    end else begin
      elapsed = cyc - last_tick - 1;
      if (t) begin
        if (elapsed == mper && run != 0) run = (run + 1 > L) ? L : run + 1;
        else run = 1;
        mper      = elapsed;
        mlock     = (run == L);
        last_tick = cyc;
        e.pv      = 1'b1;
      end else if (elapsed >= longint'(maxp)) begin
        have_ref = 0; run = 0; mlock = 0;
        e.to     = 1'b1;
      end
    end
    e.lk  = mlock;
    e.per = W'(mper);
    q.push_back(e);
    cyc++;
  endtask

  task automatic step(input logic t, input logic r);
    bus.tick_in = t;
    RST         = r;
    model_step(t, r, bus.max_period);
    @(posedge clk_in);
    #1;
  endtask

  task automatic ticks(input int period, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1);
      for (int j = 1; j < period; j++) step(1'b0, 1'b1);
    end
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({bus.period_valid, bus.timeout, bus.locked} !== {e.pv, e.to, e.lk}) begin
        errors++;
        $display("FAIL strobes t=%0t: got valid/timeout/locked=%b%b%b expected %b%b%b",
                 $time, bus.period_valid, bus.timeout, bus.locked, e.pv, e.to, e.lk);
      end
      checks++;
      if (bus.period_out !== e.per) begin
        errors++;
        $display("FAIL period_out t=%0t: got %0d expected %0d", $time, bus.period_out, e.per);
      end
    end
  end

  initial begin
    bus.tick_in    = 1'b0;
    bus.max_period = W'(100);
    // reset held while tick toggles
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    ticks(10, 8);
    ticks(5, 7);
    ticks(10, 6);
    // ticks stop: single timeout expected
    bus.max_period = W'(20);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
    // tick lands exactly on the limit
    ticks(21, 6);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    ticks(7, 6);
    // zero limit: only back-to-back ticks measure
    bus.max_period = '0;
    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 1'b1);
    // randomized segments with favoured repeat gaps so lock is reached
    for (int s = 0; s < 12; s++) begin
      bus.max_period = W'($urandom_range(2, 14));
      for (int k = 0; k < 10; k++) begin
        int gap;
        gap = ($urandom_range(0, 3) != 0) ? 4 : int'($urandom_range(0, 17));
        step(1'b1, ($urandom_range(0, 63) != 0));
        for (int j = 0; j < gap; j++) step(1'b0, 1'b1);
      end
    end
    bus.max_period = '1;
    ticks(3, 6);
    @(negedge clk_in);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
